// File: rtl/axi4_burst_master_if.sv
// axi4_if: AXI4 channel bundle used by axi4_burst_master; the master modport is the initiator view.
`ifndef AXI4_ADDR_WIDTH
`define AXI4_ADDR_WIDTH 32
`endif
`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH 64
`endif
`ifndef AXI4_WSTRB_WIDTH
`define AXI4_WSTRB_WIDTH 8
`endif
`ifndef AXI4_ID_WIDTH
`define AXI4_ID_WIDTH 4
`endif
`ifndef AXI4_DATA_BLOG
`define AXI4_DATA_BLOG 3
`endif

interface axi4_if;
  logic                         aclk;
  logic                         aresetn;
  // write address
  logic [`AXI4_ID_WIDTH-1:0]    awid;
  logic [`AXI4_ADDR_WIDTH-1:0]  awaddr;
  logic [7:0]                   awlen;
  logic [2:0]                   awsize;
  logic [1:0]                   awburst;
  logic                         awlock;
  logic [3:0]                   awcache;
  logic [2:0]                   awprot;
  logic [3:0]                   awqos;
  logic [3:0]                   awregion;
  logic                         awuser;
  logic                         awvalid;
  logic                         awready;
  // write data
  logic [`AXI4_DATA_WIDTH-1:0]  wdata;
  logic [`AXI4_WSTRB_WIDTH-1:0] wstrb;
  logic                         wlast;
  logic                         wuser;
  logic                         wvalid;
  logic                         wready;
  // write response
  logic [1:0]                   bresp;
  logic                         bvalid;
  logic                         bready;
  // read address
  logic [`AXI4_ID_WIDTH-1:0]    arid;
  logic [`AXI4_ADDR_WIDTH-1:0]  araddr;
  logic [7:0]                   arlen;
  logic [2:0]                   arsize;
  logic [1:0]                   arburst;
  logic                         arlock;
  logic [3:0]                   arcache;
  logic [2:0]                   arprot;
  logic [3:0]                   arqos;
  logic [3:0]                   arregion;
  logic                         aruser;
  logic                         arvalid;
  logic                         arready;
  // read data
  logic [`AXI4_DATA_WIDTH-1:0]  rdata;
  logic [1:0]                   rresp;
  logic                         rlast;
  logic                         rvalid;
  logic                         rready;

  modport master (
    input  aclk, aresetn,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion,
           awuser, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wuser, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion,
           aruser, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi4_burst_master.sv
// axi4_burst_master: one-outstanding AXI4 INCR burst initiator fed by a simple command port,
// with streaming write-data input and read-data output.
// Optional feature: define AXI4_BURST_MASTER_4K_CHECK_EN to fail bursts that would cross
// a 4 KB boundary without issuing any bus traffic.
`ifndef AXI4_ADDR_WIDTH
`define AXI4_ADDR_WIDTH 32
`endif
`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH 64
`endif
`ifndef AXI4_WSTRB_WIDTH
`define AXI4_WSTRB_WIDTH 8
`endif
`ifndef AXI4_ID_WIDTH
`define AXI4_ID_WIDTH 4
`endif
`ifndef AXI4_DATA_BLOG
`define AXI4_DATA_BLOG 3
`endif

module axi4_burst_master #(
  parameter logic [`AXI4_ID_WIDTH-1:0] AXI_ID = '0
) (
  axi4_if.master                       axi4,
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  input  logic                         cmd_we_i,
  input  logic [`AXI4_ADDR_WIDTH-1:0]  cmd_addr_i,
  input  logic [7:0]                   cmd_len_i,
  input  logic                         wr_valid_i,
  output logic                         wr_ready_o,
  input  logic [`AXI4_DATA_WIDTH-1:0]  wr_data_i,
  input  logic [`AXI4_WSTRB_WIDTH-1:0] wr_strb_i,
  output logic                         rd_valid_o,
  input  logic                         rd_ready_i,
  output logic [`AXI4_DATA_WIDTH-1:0]  rd_data_o,
  output logic                         rd_last_o,
  output logic                         done_o,
  output logic                         err_o
);
  typedef enum logic [2:0] {IDLE, AR, R, AW, W, B} state_t;

  state_t                        state_q, state_d;
  logic [`AXI4_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]                    len_q, len_d, cnt_q, cnt_d;
  logic                          we_q, we_d, err_q, err_d;
  logic                          arvalid_q, arvalid_d, awvalid_q, awvalid_d, bready_q, bready_d;
  logic                          done_q, done_d, err_out_q, err_out_d, cmd_ready_q, cmd_ready_d;
  logic                          last_beat, w_ph, r_ph, w_hs, r_hs;
`ifdef AXI4_BURST_MASTER_4K_CHECK_EN
  logic [15:0]                   end_off;
`endif

  // Data-phase qualifiers: the beat counter reaching len marks the final beat.
  assign last_beat = (cnt_q == len_q);
  assign w_ph      = we_q && (state_q == W);
  assign r_ph      = !we_q && (state_q == R);
  assign w_hs      = w_ph && wr_valid_i && axi4.wready;
  assign r_hs      = r_ph && axi4.rvalid && rd_ready_i;

  // Next-state, burst bookkeeping and registered-output decode.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    we_d      = we_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    done_d    = 1'b0;
    err_out_d = 1'b0;
`ifdef AXI4_BURST_MASTER_4K_CHECK_EN
    // Byte offset just past the burst, relative to the enclosing 4 KB page.
    end_off = {4'b0, cmd_addr_i[11:0]} + ((16'(cmd_len_i) + 16'd1) << `AXI4_DATA_BLOG);
`endif
    case (state_q)
      IDLE: if (cmd_valid_i && cmd_ready_q) begin
        addr_d  = cmd_addr_i;
        len_d   = cmd_len_i;
        we_d    = cmd_we_i;
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = cmd_we_i ? AW : AR;
`ifdef AXI4_BURST_MASTER_4K_CHECK_EN
        // Page-crossing burst: complete with error straight away, no bus traffic.
        if (end_off > 16'd4096) begin
          state_d   = IDLE;
          err_d     = 1'b1;
          done_d    = 1'b1;
          err_out_d = 1'b1;
        end
`endif
      end
      AR: if (axi4.arready) state_d = R;
      R: if (r_hs) begin
        cnt_d = cnt_q + 8'd1;
        // SLVERR/DECERR, or rlast disagreeing with our own beat count.
        if ((axi4.rresp >= 2'b10) || (axi4.rlast != last_beat)) err_d = 1'b1;
        if (last_beat) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          err_out_d = err_d;
        end
      end
      AW: if (axi4.awready) state_d = W;
      W: if (w_hs) begin
        cnt_d = cnt_q + 8'd1;
        if (last_beat) state_d = B;
      end
      B: if (axi4.bvalid) begin
        if (axi4.bresp >= 2'b10) err_d = 1'b1;
        state_d   = IDLE;
        done_d    = 1'b1;
        err_out_d = err_d;
      end
      default: state_d = IDLE;
    endcase
    arvalid_d   = (state_d == AR);
    awvalid_d   = (state_d == AW);
    bready_d    = (state_d == B);
    // Hold off the next command during the done pulse so IDLE lasts at least one cycle.
    cmd_ready_d = (state_d == IDLE) && !done_d;
  end

  // State and registered outputs; reset drops everything to IDLE at once.
  always_ff @(posedge axi4.aclk or negedge axi4.aresetn) begin
    if (!axi4.aresetn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      arvalid_q   <= 1'b0;
      awvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      done_q      <= 1'b0;
      err_out_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      arvalid_q   <= arvalid_d;
      awvalid_q   <= awvalid_d;
      bready_q    <= bready_d;
      done_q      <= done_d;
      err_out_q   <= err_out_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready_o    = cmd_ready_q;
  assign done_o         = done_q;
  assign err_o          = err_out_q;

  assign axi4.awid      = AXI_ID;
  assign axi4.awaddr    = addr_q;
  assign axi4.awlen     = len_q;
  assign axi4.awsize    = 3'(`AXI4_DATA_BLOG);
  assign axi4.awburst   = 2'b01;
  assign axi4.awlock    = 1'b0;
  assign axi4.awcache   = '0;
  assign axi4.awprot    = '0;
  assign axi4.awqos     = '0;
  assign axi4.awregion  = '0;
  assign axi4.awuser    = 1'b0;
  assign axi4.awvalid   = awvalid_q;

  assign axi4.wdata     = wr_data_i;
  assign axi4.wstrb     = wr_strb_i;
  assign axi4.wlast     = w_ph && last_beat;
  assign axi4.wuser     = 1'b0;
  assign axi4.wvalid    = w_ph && wr_valid_i;
  assign wr_ready_o     = w_ph && axi4.wready;

  assign axi4.bready    = bready_q;

  assign axi4.arid      = AXI_ID;
  assign axi4.araddr    = addr_q;
  assign axi4.arlen     = len_q;
  assign axi4.arsize    = 3'(`AXI4_DATA_BLOG);
  assign axi4.arburst   = 2'b01;
  assign axi4.arlock    = 1'b0;
  assign axi4.arcache   = '0;
  assign axi4.arprot    = '0;
  assign axi4.arqos     = '0;
  assign axi4.arregion  = '0;
  assign axi4.aruser    = 1'b0;
  assign axi4.arvalid   = arvalid_q;

  assign axi4.rready    = r_ph && rd_ready_i;
  assign rd_valid_o     = r_ph && axi4.rvalid;
  assign rd_data_o      = axi4.rdata;
  assign rd_last_o      = r_ph && last_beat;
endmodule

// File: doc/axi4_burst_master.md
AXI4_BURST_MASTER -- requirements
Module: axi4_burst_master

Interface
REQ-001 Parameter AXI_ID, default 0, value driven on arid/awid for every transaction.
REQ-002 axi4.aclk  input  1  single clock; all logic on rising edge.
REQ-003 axi4.aresetn  input  1  asynchronous, active-low reset.
REQ-004 axi4  axi4_if.master  --  AXI4 initiator port; widths from `AXI4_ADDR_WIDTH, `AXI4_DATA_WIDTH, `AXI4_WSTRB_WIDTH, `AXI4_ID_WIDTH.
REQ-005 cmd_valid_i  input  1  command request.
REQ-006 cmd_ready_o  output  1  command accepted when both high.
REQ-007 cmd_we_i  input  1  1 = write burst, 0 = read burst.
REQ-008 cmd_addr_i  input  `AXI4_ADDR_WIDTH  start byte address, data-width aligned.
REQ-009 cmd_len_i  input  8  beats minus one (AXI len).
REQ-010 wr_valid_i / wr_ready_o  input / output  1 / 1  write-data stream handshake.
REQ-011 wr_data_i / wr_strb_i  input  `AXI4_DATA_WIDTH / `AXI4_WSTRB_WIDTH  write beat payload.
REQ-012 rd_valid_o / rd_ready_i  output / input  1 / 1  read-data stream handshake.
REQ-013 rd_data_o / rd_last_o  output  `AXI4_DATA_WIDTH / 1  read beat payload; last beat flag.
REQ-014 done_o / err_o  output  1 / 1  one-cycle completion pulse; error flag valid with done_o.

Function
REQ-015 FSM states IDLE, AR, R, AW, W, B; reset state IDLE.
REQ-016 cmd_ready_o SHALL be 1 only in IDLE; on accept, addr/len/we registered, beat counter cleared, error flag cleared; next state AR (we=0) or AW (we=1).
REQ-017 AR: arvalid=1 with registered addr/len; arvalid held, address stable until arready; on handshake -> R.
REQ-018 AW: awvalid=1; held until awready; on handshake -> W; wvalid never asserted before AW handshake completes.
REQ-019 All bursts: size=`AXI4_DATA_BLOG, burst=INCR (2'b01); lock, cache, prot, qos, region, user fields = 0.
REQ-020 W: wvalid=wr_valid_i, wr_ready_o=wready, wdata/wstrb pass through combinationally; wlast=1 when beat counter == len; each handshake increments counter; handshake with wlast -> B.
REQ-021 wr_ready_o SHALL be 0 outside W.
REQ-022 B: bready=1; on bvalid -> IDLE; bresp[1]=1 sets error flag.
REQ-023 R: rd_valid_o=rvalid, rready=rd_ready_i, rd_data_o=rdata; rd_last_o=1 when counter == len; each handshake increments counter; rresp[1]=1 on any beat sets error flag.
REQ-024 R terminates on counter == len handshake regardless of rlast; rlast mismatch (early or missing) sets error flag.
REQ-025 rready SHALL be 0 outside R; bready 0 outside B.
REQ-026 done_o pulses one cycle after final R beat or B handshake; err_o = accumulated error flag in that cycle, else 0.
REQ-027 Next command accepted no earlier than cycle after done_o (one cycle IDLE minimum).
REQ-028 len=0: single beat, wlast/rd_last_o asserted on first beat.
REQ-029 Beat counter 8 bits; len=255 gives 256 beats without overflow ambiguity.

Reset
REQ-030 Assertion of axi4.aresetn low at any time, including mid-burst, SHALL force IDLE immediately; arvalid, awvalid, wvalid, rready, bready, done_o, err_o, rd_valid_o, wr_ready_o = 0; cmd_ready_o = 0 during reset, 1 after release.
REQ-031 Registered addr, len, we, counter, error flag reset to 0.

Configuration
REQ-032 Macro AXI4_BURST_MASTER_4K_CHECK_EN: when defined, a command where addr[11:0] + (len+1)*bytes-per-beat > 4096 SHALL be accepted, issue no AXI traffic, and produce done_o=1, err_o=1 one cycle after accept; when undefined, no check, command issued unchanged.

Verification
REQ-033 Read cmd addr=0x100 len=3, slave arready after 2 cycles, 4 OKAY beats -> arlen=3, arsize=`AXI4_DATA_BLOG, 4 rd beats, rd_last_o on 4th, done_o=1 err_o=0.
REQ-034 Write cmd addr=0x200 len=0, wr_valid_i with data 0xA5 strb all-ones -> awaddr=0x200, single beat with wlast=1, bready, done_o=1 err_o=0.
REQ-035 Write len=7 with wr_valid_i and wready randomly deasserted -> exactly 8 W handshakes, wlast on 8th only, data order preserved.
REQ-036 Read len=1, slave returns rresp=2'b10 on beat 0 and rlast on beat 0 -> 2 beats consumed, done_o=1 err_o=1.
REQ-037 Reset asserted during W beat 3 of 8 -> all valids/readies 0 same cycle, cmd_ready_o=1 after release.
REQ-038 With AXI4_BURST_MASTER_4K_CHECK_EN, read addr=0xFF8 len=1 on 64-bit bus -> no arvalid, done_o=1 err_o=1.
